// File: rtl/core_pkg.sv
// rtl/core_pkg.sv - shared constants and state type for the core's pipeline control
package core_pkg;

  localparam logic [1:0] RESULTSRC_ALU  = 2'b00;
  localparam logic [1:0] RESULTSRC_LOAD = 2'b01;
  localparam logic [1:0] RESULTSRC_PC4  = 2'b10;

  localparam logic [1:0] FWD_RF = 2'b00;
  localparam logic [1:0] FWD_W  = 2'b01;
  localparam logic [1:0] FWD_M  = 2'b10;

  typedef enum logic [1:0] {
    RUN  = 2'd0,
    WAIT = 2'd1,
    ERR  = 2'd2
  } hz_state_t;

endpackage

// File: rtl/fwd_unit.sv
// rtl/fwd_unit.sv - operand forwarding select for one E-stage source register
module fwd_unit
  import core_pkg::*;
#(
  parameter int REG_AW = 5
) (
  input  logic [REG_AW-1:0] rs_e_i,
  input  logic              regwrite_m_i,
  input  logic [REG_AW-1:0] rd_m_i,
  input  logic              regwrite_w_i,
  input  logic [REG_AW-1:0] rd_w_i,
  output logic [1:0]        fwd_o
);

  // M is younger than W, so its value is the architecturally current one
  always_comb begin
    fwd_o = FWD_RF;
    if (regwrite_m_i && (rd_m_i != '0) && (rd_m_i == rs_e_i)) begin
      fwd_o = FWD_M;
    end else if (regwrite_w_i && (rd_w_i != '0) && (rd_w_i == rs_e_i)) begin
      fwd_o = FWD_W;
    end
  end

endmodule

// File: rtl/hazard_ctrl.sv
// rtl/hazard_ctrl.sv - E/M/W control pipeline with forwarding, load-use, flush and dmem-wait stalls
module hazard_ctrl
  import core_pkg::*;
#(
  parameter int MEM_TIMEOUT = 16,
  parameter int REG_AW      = 5
) (
  input  logic              clk,
  input  logic              rst,
  input  logic [REG_AW-1:0] rs1_d,
  input  logic [REG_AW-1:0] rs2_d,
  input  logic [REG_AW-1:0] rd_d,
  input  logic              regwrite_d,
  input  logic [1:0]        resultsrc_d,
  input  logic              memwrite_d,
  input  logic              pcsrc_e,
  input  logic              dmem_ready,
  output logic              stall_f,
  output logic              stall_d,
  output logic              stall_em,
  output logic              flush_d,
  output logic              flush_e,
  output logic [1:0]        forward_a_e,
  output logic [1:0]        forward_b_e,
  output logic              regwrite_m,
  output logic              memwrite_m,
  output logic [1:0]        resultsrc_w,
  output logic              regwrite_w,
  output logic [REG_AW-1:0] rd_w,
  output logic              mem_err
);

  localparam int CNT_W = $clog2(MEM_TIMEOUT + 1);

  logic              regwrite_e_q, memwrite_e_q;
  logic [1:0]        resultsrc_e_q;
  logic [REG_AW-1:0] rd_e_q, rs1_e_q, rs2_e_q;
  logic              regwrite_m_q, memwrite_m_q;
  logic [1:0]        resultsrc_m_q;
  logic [REG_AW-1:0] rd_m_q;
  logic              regwrite_w_q, memwrite_w_q;
  logic [1:0]        resultsrc_w_q;
  logic [REG_AW-1:0] rd_w_q;
  hz_state_t         state_q;
  logic [CNT_W-1:0]  cnt_q;
  logic              mem_err_q;

  logic mem_m, memstall, load_use;

  assign mem_m    = memwrite_m_q | (resultsrc_m_q == RESULTSRC_LOAD);
  assign memstall = (mem_m & ~dmem_ready) | (state_q == ERR);
  assign load_use = (resultsrc_e_q == RESULTSRC_LOAD) && (rd_e_q != '0) &&
                    ((rd_e_q == rs1_d) || (rd_e_q == rs2_d));

  // Memory wait outranks the branch so a taken branch waits in frozen E
  always_comb begin
    stall_f  = 1'b0;
    stall_d  = 1'b0;
    stall_em = 1'b0;
    flush_d  = 1'b0;
    flush_e  = 1'b0;
    if (memstall) begin
      stall_f  = 1'b1;
      stall_d  = 1'b1;
      stall_em = 1'b1;
    end else if (pcsrc_e) begin
      flush_d = 1'b1;
      flush_e = 1'b1;
    end else if (load_use) begin
      stall_f = 1'b1;
      stall_d = 1'b1;
      flush_e = 1'b1;
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      {regwrite_e_q, resultsrc_e_q, memwrite_e_q, rd_e_q, rs1_e_q, rs2_e_q} <= '0;
      {regwrite_m_q, resultsrc_m_q, memwrite_m_q, rd_m_q} <= '0;
      {regwrite_w_q, resultsrc_w_q, memwrite_w_q, rd_w_q} <= '0;
    end else if (memstall) begin
      {regwrite_w_q, resultsrc_w_q, memwrite_w_q, rd_w_q} <= '0;
    end else begin
      {regwrite_w_q, resultsrc_w_q, memwrite_w_q, rd_w_q} <=
        {regwrite_m_q, resultsrc_m_q, memwrite_m_q, rd_m_q};
      {regwrite_m_q, resultsrc_m_q, memwrite_m_q, rd_m_q} <=
        {regwrite_e_q, resultsrc_e_q, memwrite_e_q, rd_e_q};
      if (flush_e) begin
        {regwrite_e_q, resultsrc_e_q, memwrite_e_q, rd_e_q, rs1_e_q, rs2_e_q} <= '0;
      end else begin
        {regwrite_e_q, resultsrc_e_q, memwrite_e_q, rd_e_q, rs1_e_q, rs2_e_q} <=
          {regwrite_d, resultsrc_d, memwrite_d, rd_d, rs1_d, rs2_d};
      end
    end
  end

  // cnt_q counts wait cycles already spent, saturating at MEM_TIMEOUT
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q   <= RUN;
      cnt_q     <= '0;
      mem_err_q <= 1'b0;
    end else begin
      case (state_q)
        RUN: begin
          if (mem_m && !dmem_ready) begin
            state_q <= WAIT;
            cnt_q   <= CNT_W'(1);
          end
        end
        WAIT: begin
          if (dmem_ready) begin
            state_q <= RUN;
            cnt_q   <= '0;
          end else if (cnt_q == CNT_W'(MEM_TIMEOUT)) begin
            state_q   <= ERR;
            mem_err_q <= 1'b1;
          end else begin
            cnt_q <= cnt_q + CNT_W'(1);
          end
        end
        ERR:     state_q <= ERR;
        default: state_q <= RUN;
      endcase
    end
  end

  fwd_unit #(.REG_AW(REG_AW)) u_fwd_a (
    .rs_e_i       (rs1_e_q),
    .regwrite_m_i (regwrite_m_q),
    .rd_m_i       (rd_m_q),
    .regwrite_w_i (regwrite_w_q),
    .rd_w_i       (rd_w_q),
    .fwd_o        (forward_a_e)
  );

  fwd_unit #(.REG_AW(REG_AW)) u_fwd_b (
    .rs_e_i       (rs2_e_q),
    .regwrite_m_i (regwrite_m_q),
    .rd_m_i       (rd_m_q),
    .regwrite_w_i (regwrite_w_q),
    .rd_w_i       (rd_w_q),
    .fwd_o        (forward_b_e)
  );

  assign regwrite_m  = regwrite_m_q;
  assign memwrite_m  = memwrite_m_q;
  assign resultsrc_w = resultsrc_w_q;
  assign regwrite_w  = regwrite_w_q;
  assign rd_w        = rd_w_q;
  assign mem_err     = mem_err_q;

endmodule

// File: tb/tb_hazard_ctrl.sv
// tb/tb_hazard_ctrl.sv - directed and randomized checks of hazard_ctrl against a stage-list model
module tb_hazard_ctrl;

  localparam int TMO = 4;

  logic       clk = 1'b0;
  logic       rst = 1'b1;
  logic [4:0] rs1_d = '0, rs2_d = '0, rd_d = '0;
  logic       regwrite_d = 1'b0, memwrite_d = 1'b0, pcsrc_e = 1'b0, dmem_ready = 1'b1;
  logic [1:0] resultsrc_d = '0;
  logic       stall_f, stall_d, stall_em, flush_d, flush_e;
  logic [1:0] forward_a_e, forward_b_e, resultsrc_w;
  logic       regwrite_m, memwrite_m, regwrite_w, mem_err;
  logic [4:0] rd_w;

  hazard_ctrl #(.MEM_TIMEOUT(TMO), .REG_AW(5)) dut (
    .clk(clk), .rst(rst),
    .rs1_d(rs1_d), .rs2_d(rs2_d), .rd_d(rd_d),
    .regwrite_d(regwrite_d), .resultsrc_d(resultsrc_d), .memwrite_d(memwrite_d),
    .pcsrc_e(pcsrc_e), .dmem_ready(dmem_ready),
    .stall_f(stall_f), .stall_d(stall_d), .stall_em(stall_em),
    .flush_d(flush_d), .flush_e(flush_e),
    .forward_a_e(forward_a_e), .forward_b_e(forward_b_e),
    .regwrite_m(regwrite_m), .memwrite_m(memwrite_m),
    .resultsrc_w(resultsrc_w), .regwrite_w(regwrite_w), .rd_w(rd_w),
    .mem_err(mem_err)
  );

  always #5 clk = ~clk;

  typedef struct packed {
    logic       rw;
    logic [1:0] rs;
    logic       mw;
    logic [4:0] rd;
    logic [4:0] rs1;
    logic [4:0] rs2;
  } stg_t;

  stg_t m_e, m_m, m_w;
  int   waits;
  bit   err;
  int   total = 0;
  int   passed = 0;

  task automatic chk(input string tag, input logic [7:0] obs, input logic [7:0] exp);
    total++;
    assert (obs === exp) passed++;
    else $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
  endtask

  function automatic logic [1:0] fwd_ref(input logic [4:0] r);
    if (m_m.rw && m_m.rd != 0 && m_m.rd == r) return 2'b10;
    if (m_w.rw && m_w.rd != 0 && m_w.rd == r) return 2'b01;
    return 2'b00;
  endfunction

  function automatic bit mstall_ref();
    return ((m_m.mw || m_m.rs == 2'b01) && !dmem_ready) || err;
  endfunction

  function automatic bit lu_ref();
    return m_e.rs == 2'b01 && m_e.rd != 0 && (m_e.rd == rs1_d || m_e.rd == rs2_d);
  endfunction

  task automatic model_clear();
    m_e = '0; m_m = '0; m_w = '0; waits = 0; err = 0;
  endtask

  task automatic apply(input logic rw, input logic [1:0] rs, input logic mw, input logic [4:0] rd,
                       input logic [4:0] r1, input logic [4:0] r2, input logic pc, input logic rdy);
    regwrite_d = rw; resultsrc_d = rs; memwrite_d = mw; rd_d = rd;
    rs1_d = r1; rs2_d = r2; pcsrc_e = pc; dmem_ready = rdy;
    #2;
  endtask

  task automatic check_model();
    bit ms, br, lu;
    ms = mstall_ref();
    br = !ms && pcsrc_e;
    lu = !ms && !pcsrc_e && lu_ref();
    chk("stall_f", stall_f, ms || lu);
    chk("stall_d", stall_d, ms || lu);
    chk("stall_em", stall_em, ms);
    chk("flush_d", flush_d, br);
    chk("flush_e", flush_e, br || lu);
    chk("forward_a_e", forward_a_e, fwd_ref(m_e.rs1));
    chk("forward_b_e", forward_b_e, fwd_ref(m_e.rs2));
    chk("regwrite_m", regwrite_m, m_m.rw);
    chk("memwrite_m", memwrite_m, m_m.mw);
    chk("resultsrc_w", resultsrc_w, m_w.rs);
    chk("regwrite_w", regwrite_w, m_w.rw);
    chk("rd_w", rd_w, m_w.rd);
    chk("mem_err", mem_err, err);
  endtask

  task automatic tick();
    bit ms, fe, mm;
    stg_t d;
    ms = mstall_ref();
    fe = !ms && (pcsrc_e || lu_ref());
    mm = m_m.mw || m_m.rs == 2'b01;
    d  = '{rw: regwrite_d, rs: resultsrc_d, mw: memwrite_d, rd: rd_d, rs1: rs1_d, rs2: rs2_d};
    if (!err) begin
      if (mm && !dmem_ready) begin
        waits++;
        if (waits > TMO) err = 1;
      end else begin
        waits = 0;
      end
    end
    if (ms) begin
      m_w = '0;
    end else begin
      m_w = m_m;
      m_m = m_e;
      m_e = fe ? stg_t'('0) : d;
    end
    @(posedge clk);
    #1;
  endtask

  task automatic step(input logic rw, input logic [1:0] rs, input logic mw, input logic [4:0] rd,
                      input logic [4:0] r1, input logic [4:0] r2, input logic pc, input logic rdy);
    apply(rw, rs, mw, rd, r1, r2, pc, rdy);
    check_model();
    tick();
  endtask

  task automatic do_reset();
    pcsrc_e = 1'b0;
    rst = 1'b1;
    #1;
    chk("rst_stall_f", stall_f, 0);
    chk("rst_stall_em", stall_em, 0);
    chk("rst_flush_e", flush_e, 0);
    chk("rst_rd_w", rd_w, 0);
    chk("rst_mem_err", mem_err, 0);
    model_clear();
    @(posedge clk);
    #1;
    rst = 1'b0;
  endtask

  initial begin
    model_clear();
    #3;
    chk("reset_stall_f", stall_f, 0);
    chk("reset_flush_d", flush_d, 0);
    chk("reset_fwd_a", forward_a_e, 0);
    chk("reset_regwrite_m", regwrite_m, 0);
    chk("reset_mem_err", mem_err, 0);
    @(posedge clk);
    #1;
    rst = 1'b0;

    // forwarding from M, and never for x0
    step(1, 0, 0, 5, 1, 2, 0, 1);
    step(1, 0, 0, 6, 5, 0, 0, 1);
    apply(0, 0, 0, 0, 0, 0, 0, 1); check_model(); chk("t1_fwd_a_m", forward_a_e, 2'b10); tick();
    step(1, 0, 0, 0, 1, 2, 0, 1);
    step(1, 0, 0, 6, 0, 0, 0, 1);
    apply(0, 0, 0, 0, 0, 0, 0, 1); check_model(); chk("t1_fwd_a_x0", forward_a_e, 2'b00); tick();

    // M wins over W; W used when M does not write
    step(1, 0, 0, 7, 1, 1, 0, 1);
    step(1, 0, 0, 7, 2, 2, 0, 1);
    step(1, 0, 0, 8, 1, 7, 0, 1);
    apply(0, 0, 0, 0, 0, 0, 0, 1); check_model(); chk("t2_fwd_b_m", forward_b_e, 2'b10); tick();
    step(1, 0, 0, 7, 1, 1, 0, 1);
    step(0, 0, 0, 7, 1, 1, 0, 1);
    step(1, 0, 0, 8, 1, 7, 0, 1);
    apply(0, 0, 0, 0, 0, 0, 0, 1); check_model(); chk("t2_fwd_b_w", forward_b_e, 2'b01); tick();

    // load-use bubble then W forward
    step(1, 1, 0, 3, 0, 0, 0, 1);
    apply(1, 0, 0, 4, 1, 3, 0, 1); check_model();
    chk("t3_stall_f", stall_f, 1); chk("t3_stall_d", stall_d, 1); chk("t3_flush_e", flush_e, 1);
    tick();
    apply(1, 0, 0, 4, 1, 3, 0, 1); check_model();
    chk("t3_c2_stall_f", stall_f, 0); chk("t3_c2_flush_e", flush_e, 0);
    tick();
    apply(0, 0, 0, 0, 0, 0, 0, 1); check_model(); chk("t3_fwd_b_w", forward_b_e, 2'b01); tick();

    // branch suppresses load-use
    step(1, 1, 0, 3, 0, 0, 0, 1);
    apply(1, 0, 0, 4, 3, 0, 1, 1); check_model();
    chk("t4_flush_d", flush_d, 1); chk("t4_flush_e", flush_e, 1); chk("t4_stall_f", stall_f, 0);
    tick();
    step(0, 0, 0, 0, 0, 0, 0, 1);

    // store waits 3 cycles, W gets bubbles
    step(1, 0, 0, 9, 0, 0, 0, 1);
    step(0, 0, 1, 0, 1, 2, 0, 1);
    step(0, 0, 0, 0, 0, 0, 0, 1);
    for (int k = 0; k < 3; k++) begin
      apply(0, 0, 0, 0, 0, 0, 0, 0); check_model();
      chk("t5_stall_f", stall_f, 1); chk("t5_stall_d", stall_d, 1); chk("t5_stall_em", stall_em, 1);
      chk("t5_rd_w", rd_w, (k == 0) ? 8'd9 : 8'd0);
      tick();
    end
    apply(0, 0, 0, 0, 0, 0, 0, 1); check_model();
    chk("t5_release", stall_em, 0); chk("t5_mem_err", mem_err, 0);
    tick();

    // timeout into sticky error
    step(0, 0, 1, 0, 1, 2, 0, 1);
    step(0, 0, 0, 0, 0, 0, 0, 1);
    for (int k = 0; k < TMO + 1; k++) begin
      apply(0, 0, 0, 0, 0, 0, 0, 0); check_model(); chk("t6_no_err_yet", mem_err, 0); tick();
    end
    for (int k = 0; k < 2; k++) begin
      apply(0, 0, 0, 0, 0, 0, 0, 1); check_model();
      chk("t6_mem_err", mem_err, 1); chk("t6_frozen", stall_em, 1);
      tick();
    end
    do_reset();
    step(0, 0, 1, 0, 1, 2, 0, 1);
    step(0, 0, 0, 0, 0, 0, 0, 1);
    step(0, 0, 0, 0, 0, 0, 0, 0);
    apply(0, 0, 0, 0, 0, 0, 0, 0); check_model(); chk("t6_mid_wait", stall_em, 1);
    do_reset();
    apply(0, 0, 0, 0, 0, 0, 0, 0); check_model(); chk("t6_after_rst", stall_f, 0); tick();

    // randomized traffic
    for (int i = 0; i < 600; i++) begin
      apply(1'($urandom_range(0, 1)), 2'($urandom_range(0, 2)), ($urandom_range(0, 4) == 0),
            5'($urandom_range(0, 3)), 5'($urandom_range(0, 3)), 5'($urandom_range(0, 3)),
            ($urandom_range(0, 7) == 0), ($urandom_range(0, 3) != 0));
      check_model();
      tick();
      if (err) begin
        apply(0, 0, 0, 0, 0, 0, 0, 1);
        check_model();
        do_reset();
      end
    end

    $display("%0d/%0d checks passed", passed, total);
    $finish;
  end

endmodule
